// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state encoding
// and the default preamble marker.
package ccff_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MARKER = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } ccff_state_e;

    localparam int                      DEF_MARKER_W = 16;
    localparam logic [DEF_MARKER_W-1:0] DEF_MARKER   = 16'hA5C3;
    localparam int                      BYTE_W       = 8;

endpackage

// File: rtl/ccff_byte_serializer.sv
// Byte-to-bit serializer feeding the chain head. Holds one byte, presents its
// bits LSB first, and stops accepting once CHAIN_LEN bits have been taken.
// When empty, an arriving byte's bit 0 is presented in the same cycle so a
// continuous byte stream shifts one bit per cycle without bubbles.
// The caller guarantees that while enable is high every presented bit shifts.
module ccff_byte_serializer
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       shift,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       bit_valid,
    output logic       bit_data
);

    localparam int ACC_W = $clog2(CHAIN_LEN + BYTE_W + 1);

    logic [7:0]       byte_r;
    logic [3:0]       cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic             have_s;
    logic             last_s;
    logic             room_s;
    logic             take_s;

    // Handshake decode and presentation of the next bit
    always_comb begin
        have_s    = (cnt_r != 4'd0);
        last_s    = (cnt_r == 4'd1);
        room_s    = (acc_r < ACC_W'(CHAIN_LEN));
        cfg_ready = enable && room_s && (!have_s || last_s);
        take_s    = cfg_valid && cfg_ready;
        bit_valid = have_s || take_s;
        if (have_s) begin
            bit_data = byte_r[0];
        end else if (take_s) begin
            bit_data = cfg_data[0];
        end else begin
            bit_data = 1'b0;
        end
    end

    // Byte register, remaining-bit count and tally of accepted bits
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_r <= 8'd0;
            cnt_r  <= 4'd0;
            acc_r  <= {ACC_W{1'b0}};
        end else if (take_s) begin
            acc_r <= acc_r + ACC_W'(BYTE_W);
            if (have_s) begin
                // final bit of the held byte leaves now; new byte loads whole
                byte_r <= cfg_data;
                cnt_r  <= 4'd8;
            end else if (shift) begin
                // bit 0 went straight to the chain this cycle
                byte_r <= {1'b0, cfg_data[7:1]};
                cnt_r  <= 4'd7;
            end else begin
                byte_r <= cfg_data;
                cnt_r  <= 4'd8;
            end
        end else if (shift && have_s) begin
            byte_r <= {1'b0, byte_r[7:1]};
            cnt_r  <= cnt_r - 4'd1;
        end else begin
            byte_r <= byte_r;
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain: shifts a preamble marker followed by
// CHAIN_LEN bitstream bits, and verifies the marker as it returns on the tail.
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter int                  CHAIN_LEN = 1024,
    parameter int                  MARKER_W  = DEF_MARKER_W,
    parameter logic [MARKER_W-1:0] MARKER    = MARKER_W'(DEF_MARKER)
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int               TOTAL         = CHAIN_LEN + MARKER_W;
    localparam int               CNT_W         = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] K_MARKER_LAST = CNT_W'(MARKER_W - 1);
    localparam logic [CNT_W-1:0] K_CHECK_FIRST = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] K_LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] K_MAX         = CNT_W'(TOTAL);

    ccff_state_e      state_r;
    ccff_state_e      state_nx_s;
    logic [CNT_W-1:0] k_r;
    logic [CNT_W-1:0] k_nx_s;
    logic [CNT_W-1:0] k_inc_s;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic             launch_s;
    logic             ser_enable_s;
    logic             ser_bit_valid_s;
    logic             ser_bit_s;
    logic             shift_s;
    logic             head_s;
    logic             check_s;
    logic             mismatch_s;

    // Marker bit lookup that returns 0 for any index outside the marker
    function automatic logic marker_bit(input logic [CNT_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MARKER_W; i++) begin
            if (idx == CNT_W'(i)) begin
                r = MARKER[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign ser_enable_s = (state_r == ST_DATA);

    ccff_byte_serializer #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_serializer (
        .clk       (prog_clk),
        .rst       (pReset),
        .clear     (launch_s),
        .enable    (ser_enable_s),
        .shift     (shift_s),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .bit_valid (ser_bit_valid_s),
        .bit_data  (ser_bit_s)
    );

    // Chain drive for this cycle and comparison of the returning marker
    always_comb begin
        shift_s = 1'b0;
        head_s  = 1'b0;
        case (state_r)
            ST_MARKER: begin
                shift_s = 1'b1;
                head_s  = marker_bit(k_r);
            end
            ST_DATA: begin
                shift_s = ser_bit_valid_s;
                head_s  = ser_bit_valid_s & ser_bit_s;
            end
            default: begin
                shift_s = 1'b0;
                head_s  = 1'b0;
            end
        endcase
        check_s    = shift_s && (k_r >= K_CHECK_FIRST);
        mismatch_s = check_s && (ccff_tail != marker_bit(k_r - K_CHECK_FIRST));
    end

    // Next state and shift index; a tail mismatch overrides every other move
    always_comb begin
        state_nx_s = state_r;
        k_nx_s     = k_r;
        launch_s   = 1'b0;
        k_inc_s    = (k_r != K_MAX) ? (k_r + CNT_W'(1)) : k_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    launch_s   = 1'b1;
                    state_nx_s = ST_MARKER;
                    k_nx_s     = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_MARKER: begin
                k_nx_s = k_inc_s;
                if (mismatch_s) begin
                    state_nx_s = ST_ERR;
                end else if (k_r == K_MARKER_LAST) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_MARKER;
                end
            end
            ST_DATA: begin
                if (shift_s) begin
                    k_nx_s = k_inc_s;
                end else begin
                    k_nx_s = k_r;
                end
                if (mismatch_s) begin
                    state_nx_s = ST_ERR;
                end else if (shift_s && (k_r == K_LAST)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                k_nx_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift index and registered status flags
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r <= ST_IDLE;
            k_r     <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            k_r     <= k_nx_s;
            busy_r  <= (state_nx_s == ST_MARKER) || (state_nx_s == ST_DATA);
            done_r  <= (state_nx_s == ST_DONE);
            error_r <= (state_nx_s == ST_ERR);
        end
    end

    assign ccff_head     = head_s;
    assign ccff_shift_en = shift_s;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule
